// File: rtl/db_req_arbiter_if.sv
// Bundle of requester, database and response signals around db_req_arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface db_req_arbiter_if #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int DEPTH     = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [KEY_SIZE-1:0]  req0_key;
  logic [KEY_SIZE-1:0]  req1_key;
  logic [FLAG_SIZE-1:0] req0_flag;
  logic [FLAG_SIZE-1:0] req1_flag;
  logic                 req0_valid;
  logic                 req1_valid;
  logic                 req0_ready;
  logic                 req1_ready;

  logic [KEY_SIZE-1:0]  db_in_key;
  logic [FLAG_SIZE-1:0] db_in_flag;
  logic                 db_in_valid;
  logic                 db_out_valid;
  logic [FLAG_SIZE-1:0] db_out_flag;

  logic                 rsp0_valid;
  logic                 rsp1_valid;
  logic [FLAG_SIZE-1:0] rsp0_flag;
  logic [FLAG_SIZE-1:0] rsp1_flag;

  logic [CNT_W-1:0]     outstanding;
  logic                 err_orphan;

  modport slave (
    input  req0_key, req1_key, req0_flag, req1_flag, req0_valid, req1_valid,
    input  db_out_valid, db_out_flag,
    output req0_ready, req1_ready,
    output db_in_key, db_in_flag, db_in_valid,
    output rsp0_valid, rsp1_valid, rsp0_flag, rsp1_flag,
    output outstanding, err_orphan
  );

  modport master (
    output req0_key, req1_key, req0_flag, req1_flag, req0_valid, req1_valid,
    output db_out_valid, db_out_flag,
    input  req0_ready, req1_ready,
    input  db_in_key, db_in_flag, db_in_valid,
    input  rsp0_valid, rsp1_valid, rsp0_flag, rsp1_flag,
    input  outstanding, err_orphan
  );
endinterface

// File: rtl/db_req_arbiter.sv
// Round-robin arbiter sharing the database lookup port between two requesters;
// an in-order tag FIFO remembers the source of each lookup to route responses back.
module db_req_arbiter #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int DEPTH     = 8
) (
  input  logic              clk,
  input  logic              rst,
  db_req_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]                valid;
  logic [1:0]                ready;
  logic [1:0]                accept;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      push_src;
  logic                      pop;
  logic                      head;

  logic                      last_q, last_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]          tag_q, tag_d;
  logic [KEY_SIZE-1:0]       db_key_q, db_key_d;
  logic [FLAG_SIZE-1:0]      db_flag_q, db_flag_d;
  logic                      db_valid_q, db_valid_d;
  logic [1:0]                rsp_valid_q, rsp_valid_d;
  logic [1:0][FLAG_SIZE-1:0] rsp_flag_q, rsp_flag_d;
  logic                      err_q, err_d;

  assign valid    = {bus.req1_valid, bus.req0_valid};
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign accept   = valid & ready;
  assign push     = |accept;
  assign push_src = accept[1];
  assign pop      = bus.db_out_valid & ~empty;
  assign head     = tag_q[rd_ptr_q];

  // A lone requester always wins; on a tie the one that did not win last time goes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign ready[gi]       = valid[gi] & ~full & (~valid[1-gi] | (last_q != 1'(gi)));
    assign rsp_valid_d[gi] = pop & (head == 1'(gi));
    assign rsp_flag_d[gi]  = rsp_valid_d[gi] ? bus.db_out_flag : rsp_flag_q[gi];
  end

  always_comb begin
    last_d     = last_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_d      = tag_q;
    db_key_d   = db_key_q;
    db_flag_d  = db_flag_q;
    db_valid_d = push;
    err_d      = err_q | (bus.db_out_valid & empty);

    if (push) begin
      tag_d[wr_ptr_q] = push_src;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      last_d          = push_src;
      db_key_d        = push_src ? bus.req1_key  : bus.req0_key;
      db_flag_d       = push_src ? bus.req1_flag : bus.req0_flag;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_q       <= '0;
      db_key_q    <= '0;
      db_flag_q   <= '0;
      db_valid_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_flag_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_q       <= tag_d;
      db_key_q    <= db_key_d;
      db_flag_q   <= db_flag_d;
      db_valid_q  <= db_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_flag_q  <= rsp_flag_d;
      err_q       <= err_d;
    end
  end

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.db_in_key   = db_key_q;
  assign bus.db_in_flag  = db_flag_q;
  assign bus.db_in_valid = db_valid_q;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_flag   = rsp_flag_q[0];
  assign bus.rsp1_flag   = rsp_flag_q[1];
  assign bus.outstanding = cnt_q;
  assign bus.err_orphan  = err_q;
endmodule

// File: doc/db_req_arbiter.md
# db_req_arbiter

Two-port request arbiter that shares the single key-lookup port of the database block between two network requesters, such as two Ethernet port pipelines. It accepts keyed lookups over a valid/ready handshake, grants them round-robin, issues one lookup per cycle to the database, and tracks the source of every outstanding lookup in an in-order tag FIFO. Each database response is routed back to the requester that issued the matching request. It sits in the database clock domain, between the Ethernet top-level instances and the database top.

## Interface
- KEY_SIZE, 96, lookup key width
- FLAG_SIZE, 4, request/response flag width
- DEPTH, 8, maximum outstanding lookups; power of two, ≥2
- clk  in  1  database clock; every flop in the block is on this clock
- rst  in  1  synchronous, active-high reset
- req0_key / req1_key  in  KEY_SIZE  requester key
- req0_flag / req1_flag  in  FLAG_SIZE  requester flag
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when high together with valid
- db_in_key  out  KEY_SIZE  key to the database
- db_in_flag  out  FLAG_SIZE  flag to the database
- db_in_valid  out  1  lookup strobe; the database accepts every cycle and has no backpressure
- db_out_valid  in  1  database response strobe; responses return in issue order
- db_out_flag  in  FLAG_SIZE  database response flag
- rsp0_valid / rsp1_valid  out  1  response strobe to the requester
- rsp0_flag / rsp1_flag  out  FLAG_SIZE  response flag
- outstanding  out  $clog2(DEPTH)+1  current tag-FIFO occupancy
- err_orphan  out  1  sticky flag; a response arrived with no outstanding lookup

## Operation
- **Full condition:** full = (outstanding == DEPTH), evaluated on the registered count. There is no bypass: when full, both readys are low even if a pop happens in the same cycle.
- **Arbiter:** uses a 1-bit `last` pointer.
  - If exactly one requester is valid and the block is not full, that requester gets ready = 1.
  - If both are valid, the requester ≠ `last` wins; the other sees ready = 0.
  - At most one ready is high per cycle.
  - A requester's ready is never high while its valid is low.
  - `last` updates only on an accept.
- **Accept (valid & ready):**
  - Register key and flag into db_in_key/db_in_flag and set db_in_valid = 1 for the next cycle.
  - Push the source ID (0/1) into the tag FIFO.
  - With no accept, db_in_valid = 0 next cycle. db_in_key/db_in_flag hold their last values.
- **Response (db_out_valid):**
  - If outstanding > 0: pop the FIFO head. Next cycle, drive rsp<head>_valid = 1 with rsp<head>_flag = db_out_flag. The other rsp_valid stays 0.
  - If outstanding == 0: no pop, no rsp_valid, and err_orphan is set.
- **Simultaneous push and pop:** count unchanged and pointers both advance. Pointers wrap modulo DEPTH.
- **Count range:** outstanding is always between 0 and DEPTH.
- **err_orphan:** cleared only by rst.

## Timing
- Request accepted at cycle T → db_in_valid high at T+1, exactly one cycle.
- db_out_valid at cycle R → rspN_valid high at R+1, exactly one cycle.
- Sustained throughput is one accept per cycle while not full.
- Both-valid contention alternates 0,1,0,1…
- The outstanding count reflects the accept/pop of cycle T at T+1.
- readys are combinational from the valids, `last` and the registered count. There is no combinational path from db_out_valid to ready.
- **Reset values:**
  - All outputs 0: readys, db_in_valid, db_in_key, db_in_flag, rsp*_valid, rsp*_flag, outstanding, err_orphan.
  - FIFO pointers 0.
  - last = 1, so req0 wins the first tie.
- **Reset mid-operation:**
  - Outstanding tags are discarded and a pending db_in_valid/rsp_valid is cancelled.
  - Database responses to pre-reset lookups arriving after reset are orphans and set err_orphan.

## Test plan
- **Single requester:** after reset, req0 valid with key 0x0123…AB and flag 0x3 for 1 cycle → db_in_valid at T+1 with the same key/flag, outstanding = 1. Then db_out_valid with flag 0x9 → rsp0_valid = 1 with flag 0x9 one cycle later; rsp1_valid stays 0; outstanding = 0.
- **Contention:** req0 and req1 both held valid for 6 cycles, DB latency 3 → grant order 0,1,0,1,0,1. Responses route to rsp0,rsp1,rsp0,rsp1,rsp0,rsp1 in order, each with its DB flag.
- **Full:** DEPTH = 8, DB silent, req1 valid continuously → exactly 8 accepts, then ready = 0 and outstanding = 8. A pop at the same cycle keeps ready low that cycle; ready rises the next cycle and the 9th accept follows.
- **Simultaneous push/pop at count 5** → outstanding stays 5. Then run 20 transactions through the FIFO to exercise pointer wrap; all responses route correctly.
- **Orphan:** db_out_valid with outstanding = 0 → no rsp_valid, err_orphan = 1 and it stays 1 through later traffic until rst.
- **Reset mid-flight:** 3 lookups outstanding, then rst for 1 cycle → outstanding = 0, all outputs 0. A late db_out_valid sets err_orphan; a new req1 accept routes its response to rsp1.
